// File: rtl/nand_rd_pkg.sv
// Shared types and constants for the NAND read-data packer: FSM states,
// word geometry and the byte-pair insertion helper.
package nand_rd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int WORD_W         = 64;
    localparam int BYTES_PER_WORD = 8;
    localparam int PAIRS_PER_WORD = BYTES_PER_WORD / 2;
    localparam int SLOT_W         = $clog2(PAIRS_PER_WORD);

    // Slot s holds the rise byte at byte 2s and the fall byte at byte 2s+1.
    function automatic logic [WORD_W-1:0] insert_pair(
        input logic [WORD_W-1:0] word,
        input logic [SLOT_W-1:0] slot,
        input logic [7:0]        rise,
        input logic [7:0]        fall
    );
        logic [WORD_W-1:0] w;
        w = word;
        w[int'(slot)*16 +: 8]     = rise;
        w[int'(slot)*16 + 8 +: 8] = fall;
        return w;
    endfunction

endpackage

// File: rtl/nand_rd_fifo.sv
// Synchronous FIFO for packed words; head reads as zero while empty so the
// packer outputs are all-zero after reset.
module nand_rd_fifo
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 65
)
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // A pop frees the head slot in the same cycle, so a full FIFO may still accept.
    assign do_wr = push && (!full || pop);
    assign do_rd = pop && !empty;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/nand_rd_packer.sv
// Packs captured DDR byte pairs into 64-bit words for the page buffer.
// Optional build macro RD_CHECKSUM_EN enables the running XOR checksum.
module nand_rd_packer
    import nand_rd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
)
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [LEN_W-1:0] len_bytes,
    input  logic             in_valid,
    input  logic [7:0]       in_rise,
    input  logic [7:0]       in_fall,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             stray,
    output logic [7:0]       checksum
);

    state_t              state;
    state_t              state_nx;
    logic [LEN_W-1:0]    count;
    logic [SLOT_W-1:0]   slot;
    logic [WORD_W-1:0]   partial;
    logic [WORD_W-1:0]   word_nx;
    logic [WORD_W-1:0]   push_word;
    logic [WORD_W:0]     push_data;
    logic [WORD_W:0]     head;
    logic                push;
    logic                push_last;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                start_ok;
    logic                len_bad;
    logic                pair_ok;
    logic                last_pair;
    logic                slot_wrap;

    assign start_ok  = (state == IDLE) && start;
    assign len_bad   = (len_bytes == '0) || len_bytes[0];
    assign pair_ok   = (state == CAPTURE) && in_valid;
    assign last_pair = (count == LEN_W'(2));
    assign slot_wrap = (slot == SLOT_W'(PAIRS_PER_WORD - 1));
    assign word_nx   = insert_pair(partial, slot, in_rise, in_fall);
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = len_bad ? DONE : CAPTURE;
            CAPTURE: if (pair_ok && last_pair) state_nx = slot_wrap ? DONE : FLUSH;
            FLUSH:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Full words go straight into the FIFO on their completing pair; a partial
    // final word waits one cycle in FLUSH.
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        push_word = partial;
        if (pair_ok && slot_wrap) begin
            push      = 1'b1;
            push_last = last_pair;
            push_word = word_nx;
        end else if (state == FLUSH) begin
            push      = 1'b1;
            push_last = 1'b1;
        end
        push_data = {push_last, push_word};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count    <= '0;
            slot     <= '0;
            partial  <= '0;
            overflow <= 1'b0;
            stray    <= 1'b0;
        end else begin
            if (start_ok) begin
                count    <= len_bytes;
                slot     <= '0;
                partial  <= '0;
                overflow <= 1'b0;
            end else if (pair_ok) begin
                count   <= count - LEN_W'(2);
                slot    <= slot + SLOT_W'(1);
                partial <= slot_wrap ? '0 : word_nx;
            end else if (state == FLUSH) begin
                partial <= '0;
            end
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (in_valid && (state != CAPTURE)) stray <= 1'b1;
            else if (start_ok)                  stray <= 1'b0;
        end
    end

`ifdef RD_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)       csum <= '0;
        else if (start_ok) csum <= '0;
        else if (pair_ok)  csum <= csum ^ in_rise ^ in_fall;
    end

    assign checksum = csum;
`else
    assign checksum = 8'h00;
`endif

    nand_rd_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (WORD_W + 1)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[WORD_W-1:0];
    assign out_last  = head[WORD_W];
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_nand_rd_packer.sv
// Scoreboard bench for nand_rd_packer: directed bursts push expected words,
// a monitor pops and compares each accepted output word.
module tb_nand_rd_packer;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [15:0] len_bytes;
    logic        in_valid;
    logic [7:0]  in_rise;
    logic [7:0]  in_fall;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        stray;
    logic [7:0]  checksum;

    int n_cmp = 0;
    int n_bad = 0;
    logic [64:0] exp_q [$];

    nand_rd_packer #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .start     (start),
        .len_bytes (len_bytes),
        .in_valid  (in_valid),
        .in_rise   (in_rise),
        .in_fall   (in_fall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .stray     (stray),
        .checksum  (checksum)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got %h last %0b required no word", out_data, out_last);
            end else begin
                check("out_word", {out_last, out_data}, exp_q.pop_front());
            end
        end
    end

    function automatic logic [63:0] word_of(input int base);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(base + i);
        return w;
    endfunction

    task automatic reset_checks(input string tag);
        check({tag, "_out_valid"}, 65'(out_valid), 65'd0);
        check({tag, "_out_data"},  65'(out_data),  65'd0);
        check({tag, "_out_last"},  65'(out_last),  65'd0);
        check({tag, "_busy"},      65'(busy),      65'd0);
        check({tag, "_done"},      65'(done),      65'd0);
        check({tag, "_overflow"},  65'(overflow),  65'd0);
        check({tag, "_stray"},     65'(stray),     65'd0);
        check({tag, "_checksum"},  65'(checksum),  65'd0);
    endtask

    task automatic start_burst(input logic [15:0] len);
        start = 1'b1;
        len_bytes = len;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] r, input logic [7:0] f);
        in_valid = 1'b1;
        in_rise  = r;
        in_fall  = f;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 65'(seen), 65'd1);
        @(negedge CLK);
        check({tag, "_done_pulse_end"}, 65'(done), 65'd0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
            @(negedge CLK);
            #1;
        end
        check({tag, "_drained"}, 65'(exp_q.size()), 65'd0);
    endtask

    initial begin
        RST_N = 1'b0;
        start = 1'b0;
        len_bytes = '0;
        in_valid = 1'b0;
        in_rise = '0;
        in_fall = '0;
        out_ready = 1'b1;
        #1;
        reset_checks("init");
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // Scenario 1: 4-byte partial word
        exp_q.push_back({1'b1, 64'h00000000_EFBEADDE});
        start_burst(16'd4);
        check("s1_busy", 65'(busy), 65'd1);
        send_pair(8'hDE, 8'hAD);
        send_pair(8'hBE, 8'hEF);
        wait_done("s1");
`ifdef RD_CHECKSUM_EN
        check("s1_checksum", 65'(checksum), 65'h22);
`else
        check("s1_checksum", 65'(checksum), 65'h00);
`endif
        wait_drain("s1");
        check("s1_idle", 65'(busy), 65'd0);

        // Scenario 2: two full words, streaming
        exp_q.push_back({1'b0, 64'h07060504_03020100});
        exp_q.push_back({1'b1, 64'h0F0E0D0C_0B0A0908});
        start_burst(16'd16);
        for (int k = 0; k < 8; k++) begin
            send_pair(8'(2*k), 8'(2*k + 1));
            if (k == 3) check("s2_latency", 65'(out_valid), 65'd1);
        end
        wait_done("s2");
        wait_drain("s2");

        // Scenario 3: stalled consumer, FIFO fills then overflows
        out_ready = 1'b0;
        for (int w = 0; w < 4; w++) exp_q.push_back({1'b0, word_of(8*w)});
        start_burst(16'd48);
        for (int k = 0; k < 24; k++) begin
            send_pair(8'(2*k), 8'(2*k + 1));
            if (k == 15) check("s3_no_overflow_at_full", 65'(overflow), 65'd0);
        end
        check("s3_overflow", 65'(overflow), 65'd1);
        wait_done("s3");
        check("s3_hold_data", 65'(out_data), 65'(word_of(0)));
        check("s3_hold_last", 65'(out_last), 65'd0);
        @(posedge CLK);
        #1;
        out_ready = 1'b1;
        wait_drain("s3");
        check("s3_overflow_sticky", 65'(overflow), 65'd1);

        // Scenario 4: stray pair in IDLE, cleared by the next start
        send_pair(8'h55, 8'h66);
        check("s4_stray", 65'(stray), 65'd1);
        check("s4_no_word", 65'(out_valid), 65'd0);
        exp_q.push_back({1'b1, 64'h00000000_44332211});
        start_burst(16'd4);
        check("s4_stray_clear", 65'(stray), 65'd0);
        check("s4_overflow_clear", 65'(overflow), 65'd0);
        send_pair(8'h11, 8'h22);
        send_pair(8'h33, 8'h44);
        wait_done("s4");
`ifdef RD_CHECKSUM_EN
        check("s4_checksum", 65'(checksum), 65'h44);
`else
        check("s4_checksum", 65'(checksum), 65'h00);
`endif
        wait_drain("s4");

        // Illegal lengths: odd and zero emit nothing
        start_burst(16'd5);
        wait_done("odd");
        check("odd_no_word", 65'(out_valid), 65'd0);
        start_burst(16'd0);
        wait_done("zero");
        check("zero_no_word", 65'(out_valid), 65'd0);

        // Scenario 5: reset mid-burst, then a clean burst
        start_burst(16'd16);
        send_pair(8'h90, 8'h91);
        send_pair(8'h92, 8'h93);
        send_pair(8'h94, 8'h95);
        RST_N = 1'b0;
        #1;
        reset_checks("midrst");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        exp_q.push_back({1'b1, 64'hA7A6A5A4_A3A2A1A0});
        start_burst(16'd8);
        for (int k = 0; k < 4; k++) send_pair(8'(8'hA0 + 2*k), 8'(8'hA1 + 2*k));
        wait_done("s5");
        wait_drain("s5");
        check("final_no_word", 65'(out_valid), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
